mod_mult_arbiter: RTL and testbench

Shares one pipelined modular_multiplier (30-bit operands, fixed modulus q) between NUM_REQ requesters, e.g. the butterfly units and twiddle-update logic of the NTT core. Each cycle, a round-robin arbiter grants at most one valid request and drives its operands into the multiplier. A tag pipeline routes each product back to its originator exactly MULT_LATENCY+1 cycles after acceptance. The multiplier is instantiated next to this block and connected through the mult_* ports.

---
 rtl/ntt_pkg.sv | 15 +
 rtl/mod_mult_arbiter_rr_arbiter.sv | 27 ++
 rtl/mod_mult_arbiter.sv | 82 ++++++++
 tb/tb_mod_mult_arbiter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// ntt_pkg: shared constants and tag-entry type for the NTT modular-multiply path
package ntt_pkg;

    localparam int WIDTH = 30;
    localparam logic [WIDTH-1:0] Q = 30'd998244353;
    localparam int MULT_LATENCY = 3;
    localparam int NUM_REQ = 4;
    localparam int TAG_W = $clog2(NUM_REQ);

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/mod_mult_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or above ptr
module rr_arbiter #(
    parameter int N = 4,
    localparam int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] grant_id,
    output logic            grant_any
);

    logic [ID_W-1:0] idx;

    // Scan downward from the farthest candidate so the closest one to ptr wins
    always_comb begin
        idx = '0;
        grant_id = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = ID_W'((int'(ptr) + k) % N);
            if (req[idx]) grant_id = idx;
        end
        grant_any = |req;
        grant = grant_any ? (N'(1) << grant_id) : '0;
    end

endmodule

// File: rtl/mod_mult_arbiter.sv
// mod_mult_arbiter: shares one pipelined modular multiplier among NUM_REQ requesters
module mod_mult_arbiter #(
    parameter int NUM_REQ = ntt_pkg::NUM_REQ,
    parameter int WIDTH = ntt_pkg::WIDTH,
    parameter int MULT_LATENCY = ntt_pkg::MULT_LATENCY
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic [WIDTH-1:0]         rsp_data,
    output logic [WIDTH-1:0]         mult_a,
    output logic [WIDTH-1:0]         mult_b,
    input  logic [WIDTH-1:0]         mult_c,
    output logic                     busy
);

    localparam int ID_W = $clog2(NUM_REQ);
    localparam logic [ID_W-1:0] LAST = ID_W'(NUM_REQ - 1);

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;

    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  grant_id;
    logic             grant_any;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    tag_t             tag [MULT_LATENCY+1];

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req(req_valid),
        .ptr(ptr),
        .grant(req_ready),
        .grant_id(grant_id),
        .grant_any(grant_any)
    );

    // Mux the granted operands; an all-zero grant yields zero operands when idle
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
                sel_a = sel_a | req_a[i*WIDTH +: WIDTH];
                sel_b = sel_b | req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    // Pointer, operand registers, tag shift pipe and registered response
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= '0;
            mult_a <= '0;
            mult_b <= '0;
            rsp_valid <= '0;
            rsp_data <= '0;
            for (int s = 0; s <= MULT_LATENCY; s++) tag[s] <= '0;
        end else begin
            if (grant_any) ptr <= (grant_id == LAST) ? '0 : grant_id + 1'b1;
            mult_a <= sel_a;
            mult_b <= sel_b;
            tag[0] <= '{valid: grant_any, id: grant_id};
            for (int s = 1; s <= MULT_LATENCY; s++) tag[s] <= tag[s-1];
            rsp_valid <= tag[MULT_LATENCY].valid ? (NUM_REQ'(1) << tag[MULT_LATENCY].id) : '0;
            if (tag[MULT_LATENCY].valid) rsp_data <= mult_c;
        end
    end

    // Busy while any tag stage still carries a product in flight
    always_comb begin
        busy = 1'b0;
        for (int s = 0; s <= MULT_LATENCY; s++) busy = busy | tag[s].valid;
    end

endmodule

// File: tb/tb_mod_mult_arbiter.sv
// tb_mod_mult_arbiter: randomized scoreboard bench with a behavioural multiplier and arbiter model
module tb_mod_mult_arbiter;
    import ntt_pkg::*;

    localparam int N = 4;
    localparam int W = WIDTH;
    localparam int L = MULT_LATENCY;

    typedef struct {
        int         id;
        logic [W-1:0] prod;
        int         due;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     req_valid = '0;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_a = '0;
    logic [N*W-1:0]   req_b = '0;
    logic [N-1:0]     rsp_valid;
    logic [W-1:0]     rsp_data;
    logic [W-1:0]     mult_a;
    logic [W-1:0]     mult_b;
    logic [W-1:0]     mult_c;
    logic             busy;
    logic [W-1:0]     mpipe [L] = '{default: '0};

    exp_t             sb [$];
    int               cyc = 0;
    int               checks = 0;
    int               errors = 0;
    bit               mon_on = 1'b0;
    logic [W-1:0]     last_data = '0;
    int               ptr_m = 0;
    logic [W-1:0]     exp_a = '0;
    logic [W-1:0]     exp_b = '0;

    always #5 clk = ~clk;

    mod_mult_arbiter #(.NUM_REQ(N), .WIDTH(W), .MULT_LATENCY(L)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a(req_a),
        .req_b(req_b),
        .rsp_valid(rsp_valid),
        .rsp_data(rsp_data),
        .mult_a(mult_a),
        .mult_b(mult_b),
        .mult_c(mult_c),
        .busy(busy)
    );

    function automatic logic [W-1:0] modmul(input logic [W-1:0] a, input logic [W-1:0] b);
        longint unsigned x = 64'(a);
        longint unsigned y = 64'(b);
        return W'((x * y) % 64'(Q));
    endfunction

    function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h at cycle %0d", name, got, want, cyc);
        end
    endfunction

    function automatic logic [N*W-1:0] rnd_ops();
        logic [N*W-1:0] v = '0;
        for (int i = 0; i < N; i++) begin
            logic [W-1:0] x = ($urandom_range(0, 1) != 0) ? W'($urandom_range(0, 1000)) : W'($urandom);
            v = v | ((N*W)'(x) << (W * i));
        end
        return v;
    endfunction

    // Behavioural stand-in for the external multiplier: L-deep pipeline of a*b mod Q
    always @(posedge clk) begin
        mpipe[0] <= modmul(mult_a, mult_b);
        for (int i = 1; i < L; i++) mpipe[i] <= mpipe[i-1];
    end
    assign mult_c = mpipe[L-1];

    // Cycle counter; a reset edge discards every outstanding expectation
    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            sb.delete();
            last_data = '0;
        end
    end

    // Monitor: pops the scoreboard when an expected response is due, else expects silence
    always @(negedge clk) begin
        exp_t e;
        if (mon_on) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                chk("rsp_valid", 64'(rsp_valid), 64'(1) << e.id);
                chk("rsp_data", 64'(rsp_data), 64'(e.prod));
                last_data = e.prod;
            end else begin
                chk("rsp_idle", 64'(rsp_valid), 64'd0);
                chk("rsp_hold", 64'(rsp_data), 64'(last_data));
            end
            chk("busy", 64'(busy), 64'(sb.size() > 0));
        end
    end

    task automatic step(input logic r, input logic [N-1:0] v, input logic [N*W-1:0] a, input logic [N*W-1:0] b);
        int g;
        logic [$clog2(N)-1:0] i;
        logic [W-1:0] ea;
        logic [W-1:0] eb;
        @(negedge clk);
        rst_n = r;
        req_valid = v;
        req_a = a;
        req_b = b;
        #1;
        chk("mult_a", 64'(mult_a), 64'(exp_a));
        chk("mult_b", 64'(mult_b), 64'(exp_b));
        g = -1;
        if (r) begin
            for (int k = 0; k < N; k++) begin
                i = $clog2(N)'((ptr_m + k) % N);
                if (v[i]) begin
                    g = int'(i);
                    break;
                end
            end
        end
        chk("req_ready", 64'(req_ready), (g < 0) ? 64'd0 : (64'(1) << g));
        if (!r) begin
            ptr_m = 0;
            exp_a = '0;
            exp_b = '0;
        end else if (g >= 0) begin
            ea = W'(a >> (W * g));
            eb = W'(b >> (W * g));
            sb.push_back('{g, modmul(ea, eb), cyc + L + 2});
            ptr_m = (g + 1) % N;
            exp_a = ea;
            exp_b = eb;
        end else begin
            exp_a = '0;
            exp_b = '0;
        end
    endtask

    initial begin
        logic r;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_rsp_data", 64'(rsp_data), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_mult_a", 64'(mult_a), 64'd0);
        chk("reset_mult_b", 64'(mult_b), 64'd0);
        mon_on = 1'b1;
        step(1'b1, 4'b0001, {90'd0, 30'd10}, {90'd0, 30'd10});
        repeat (8) step(1'b1, '0, '0, '0);
        repeat (8) step(1'b1, 4'hF, {30'd0, 30'd40, 30'd90, 30'd5}, {30'd10000, 30'd23, 30'd30, 30'd5});
        repeat (6) step(1'b1, '0, '0, '0);
        repeat (8) step(1'b1, 4'b1010, rnd_ops(), rnd_ops());
        repeat (6) step(1'b1, '0, '0, '0);
        step(1'b1, 4'b0100, {30'd0, 30'd123456, 60'd0}, {30'd0, 30'd7891234, 60'd0});
        step(1'b1, 4'b0100, {30'd0, 30'd2, 60'd0}, {30'd0, 30'd3, 60'd0});
        repeat (6) step(1'b1, '0, '0, '0);
        repeat (3) step(1'b1, 4'hF, rnd_ops(), rnd_ops());
        step(1'b0, '0, '0, '0);
        repeat (8) step(1'b1, '0, '0, '0);
        repeat (10) step(1'b1, '0, rnd_ops(), rnd_ops());
        repeat (400) begin
            r = ($urandom_range(0, 49) != 0);
            step(r, r ? N'($urandom) : '0, rnd_ops(), rnd_ops());
        end
        repeat (L + 4) step(1'b1, '0, '0, '0);
        chk("drain", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
